bit_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detector datapath. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on `out_bit`, which drives the detector's serial `inp`. A one-word holding register lets consecutive words stream with no idle gap between frames. Between words the line carries a fixed idle level.

---
 rtl/bit_serializer.sv | 82 ++++++++
 tb/tb_bit_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bit stream out.
// A one-word holding register lets consecutive words stream with no idle cycles between frames.
module bit_serializer #(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             out_bit,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] shreg;
   logic             hold_full;
   logic [CW-1:0]    bit_cnt;
   logic             accept;
   logic             xfer;

   // Handshake: a word moves when data_valid and data_ready are both high at a rising
   // edge; upstream keeps data_in stable while data_valid is high and data_ready is low.
   assign data_ready = ~hold_full;
   assign accept     = data_valid & ~hold_full;

   // Load the shifter from hold when idle, or on the last bit so the next MSB follows directly.
   assign xfer = hold_full & ((state == IDLE) | (bit_cnt == LAST));
   assign busy = (state == SHIFT) | hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         hold        <= '0;
         hold_full   <= 1'b0;
         shreg       <= '0;
         bit_cnt     <= '0;
         out_bit     <= IDLE_BIT;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // accept and xfer are mutually exclusive: xfer needs hold_full, accept needs it clear.
         if (accept) begin
            hold      <= data_in;
            hold_full <= 1'b1;
         end
         if (xfer) begin
            shreg       <= hold;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
            state       <= SHIFT;
            out_bit     <= hold[WIDTH-1];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
         end else if (state == SHIFT) begin
            frame_start <= 1'b0;
            if (bit_cnt != LAST) begin
               bit_cnt <= bit_cnt + 1'b1;
               shreg   <= {shreg[WIDTH-2:0], 1'b0};
               out_bit <= shreg[WIDTH-2];
            end else begin
               state     <= IDLE;
               out_bit   <= IDLE_BIT;
               bit_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an 8-bit/idle-0 instance and a 2-bit/idle-1 instance side by side,
// each compared every cycle against a bit-queue model of the serial line.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] data8 = '0;
   logic       dv8 = 1'b0;
   logic       rdy8, ob8, bv8, fs8, busy8;
   logic [1:0] data2 = '0;
   logic       dv2 = 1'b0;
   logic       rdy2, ob2, bv2, fs2, busy2;

   bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut8 (
      .clk(clk), .rst(rst), .data_in(data8), .data_valid(dv8), .data_ready(rdy8),
      .out_bit(ob8), .bit_valid(bv8), .frame_start(fs8), .busy(busy8)
   );

   bit_serializer #(.WIDTH(2), .IDLE_BIT(1'b1)) dut2 (
      .clk(clk), .rst(rst), .data_in(data2), .data_valid(dv2), .data_ready(rdy2),
      .out_bit(ob2), .bit_valid(bv2), .frame_start(fs2), .busy(busy2)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: each entry is {first_bit_of_word, bit}; the line pops one entry per edge.
   logic [1:0] exp8_q[$];
   logic [1:0] exp2_q[$];
   int         pend8 = 0;
   int         pend2 = 0;
   logic       m_out8 = 1'b0, m_val8 = 1'b0, m_fs8 = 1'b0;
   logic       m_out2 = 1'b1, m_val2 = 1'b0, m_fs2 = 1'b0;
   logic       acc8 = 1'b0, acc2 = 1'b0, in_rst = 1'b0;

   int          fs_cnt8 = 0;
   int          fs0;
   logic        det_on = 1'b0;
   logic [2:0]  win = '0;
   int          det_cnt = 0;
   logic [31:0] det_mask = '0;
   logic        cap_on = 1'b0;
   logic [31:0] cap2 = '0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model8(input logic acc, input logic [7:0] d);
      logic [1:0] e;
      if (exp8_q.size() > 0) begin
         e = exp8_q.pop_front();
         m_out8 = e[0]; m_val8 = 1'b1; m_fs8 = e[1];
         if (e[1]) pend8--;
      end else begin
         m_out8 = 1'b0; m_val8 = 1'b0; m_fs8 = 1'b0;
      end
      if (acc) begin
         for (int i = 7; i >= 0; i--) exp8_q.push_back({i == 7, d[i]});
         pend8++;
      end
   endtask

   task automatic model2(input logic acc, input logic [1:0] d);
      logic [1:0] e;
      if (exp2_q.size() > 0) begin
         e = exp2_q.pop_front();
         m_out2 = e[0]; m_val2 = 1'b1; m_fs2 = e[1];
         if (e[1]) pend2--;
      end else begin
         m_out2 = 1'b1; m_val2 = 1'b0; m_fs2 = 1'b0;
      end
      if (acc) begin
         for (int i = 1; i >= 0; i--) exp2_q.push_back({i == 1, d[i]});
         pend2++;
      end
   endtask

   task automatic clear_models();
      exp8_q.delete(); exp2_q.delete();
      pend8 = 0; pend2 = 0;
      m_out8 = 1'b0; m_val8 = 1'b0; m_fs8 = 1'b0;
      m_out2 = 1'b1; m_val2 = 1'b0; m_fs2 = 1'b0;
   endtask

   task automatic check_all();
      chk1("out_bit8", ob8, m_out8);
      chk1("bit_valid8", bv8, m_val8);
      chk1("frame_start8", fs8, m_fs8);
      chk1("data_ready8", rdy8, pend8 == 0);
      chk1("busy8", busy8, m_val8 | (pend8 > 0));
      chk1("out_bit2", ob2, m_out2);
      chk1("bit_valid2", bv2, m_val2);
      chk1("frame_start2", fs2, m_fs2);
      chk1("data_ready2", rdy2, pend2 == 0);
      chk1("busy2", busy2, m_val2 | (pend2 > 0));
   endtask

   task automatic step();
      acc8 = !in_rst && dv8 && (pend8 == 0);
      acc2 = !in_rst && dv2 && (pend2 == 0);
      @(posedge clk);
      if (in_rst) clear_models();
      else begin
         model8(acc8, data8);
         model2(acc2, data2);
      end
      #1;
      check_all();
      if (fs8) fs_cnt8++;
      if (det_on && bv8) begin
         win = {win[1:0], ob8};
         if (det_cnt >= 2 && win == 3'b110) det_mask[det_cnt] = 1'b1;
         det_cnt++;
      end
      if (cap_on && bv2) cap2 = {cap2[30:0], ob2};
   endtask

   // Asserts rst between edges and checks the outputs before any edge arrives.
   task automatic reset_async();
      rst = 1'b1;
      in_rst = 1'b1;
      #1;
      clear_models();
      check_all();
      step();
      rst = 1'b0;
      in_rst = 1'b0;
   endtask

   task automatic send8(input logic [7:0] d);
      logic got = 1'b0;
      data8 = d;
      dv8 = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         got = acc8;
      end
      chk1("accept8_in_time", got, 1'b1);
   endtask

   task automatic send2(input logic [1:0] d);
      logic got = 1'b0;
      data2 = d;
      dv2 = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         got = acc2;
      end
      chk1("accept2_in_time", got, 1'b1);
   endtask

   initial begin
      #2;
      reset_async();

      // single word, then back to idle
      send8(8'hD0); dv8 = 1'b0;
      repeat (10) step();

      // back-to-back words with a 110 detector watching the line
      det_on = 1'b1; fs0 = fs_cnt8;
      send8(8'hC3); send8(8'h5A); dv8 = 1'b0;
      repeat (18) step();
      det_on = 1'b0;
      chkn("det110_positions", det_mask, 32'h0000_2104);
      chkn("b2b_frames", 32'(fs_cnt8 - fs0), 32'd2);

      // stall: 8'hAA waits with valid high while hold is occupied
      fs0 = fs_cnt8;
      send8(8'h0F); send8(8'h33); send8(8'hAA); dv8 = 1'b0;
      repeat (30) step();
      chkn("stall_frames", 32'(fs_cnt8 - fs0), 32'd3);

      // reset after bit 3 of 8'hFF, then a clean 8'h81
      send8(8'hFF); dv8 = 1'b0;
      repeat (4) step();
      reset_async();
      fs0 = fs_cnt8;
      send8(8'h81); dv8 = 1'b0;
      repeat (10) step();
      chkn("after_reset_frames", 32'(fs_cnt8 - fs0), 32'd1);

      // narrow instance, idle level 1
      cap_on = 1'b1;
      send2(2'b10); send2(2'b01); send2(2'b11); dv2 = 1'b0;
      repeat (6) step();
      cap_on = 1'b0;
      chkn("w2_stream", cap2, 32'h0000_0027);

      // random traffic on both instances, with one reset in the middle
      for (int c = 0; c < 400; c++) begin
         if (!dv8 || acc8) begin
            data8 = 8'($urandom);
            dv8 = ($urandom_range(0, 3) != 0);
         end
         if (!dv2 || acc2) begin
            data2 = 2'($urandom);
            dv2 = ($urandom_range(0, 2) != 0);
         end
         if (c == 200) reset_async();
         else step();
      end
      dv8 = 1'b0; dv2 = 1'b0;
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
